// File: rtl/sobel_gradient.sv
// sobel_gradient: 3x3 Sobel gradient magnitude with saturation and threshold, three register stages.
// Input-side column/row counters mask the two-pixel top and left border of each frame.
module sobel_gradient #(
    parameter int IMAGE_W = 640,
    parameter int IMAGE_H = 480
) (
    input  logic        InClk,
    input  logic        InRst_n,
    input  logic        InMatrixDe,
    input  logic [23:0] InMatrixData1,
    input  logic [23:0] InMatrixData2,
    input  logic [23:0] InMatrixData3,
    input  logic [7:0]  InThreshold,
    output logic [7:0]  OutData,
    output logic        OutEdge,
    output logic        OutDe
);

    localparam logic [15:0] ROW_LAST = 16'(IMAGE_H - 1);

    // Counters are 16 bits wide; reject geometries they cannot represent.
    if (IMAGE_W < 1 || IMAGE_W > 65536 || IMAGE_H < 1 || IMAGE_H > 65536) begin : g_bad_size
        $error("sobel_gradient: IMAGE_W/IMAGE_H out of range");
    end

    logic [7:0] p11, p12, p13;
    logic [7:0] p21, p23;
    logic [7:0] p31, p32, p33;

    assign p11 = InMatrixData1[23:16];
    assign p12 = InMatrixData1[15:8];
    assign p13 = InMatrixData1[7:0];
    assign p21 = InMatrixData2[23:16];
    assign p23 = InMatrixData2[7:0];
    assign p31 = InMatrixData3[23:16];
    assign p32 = InMatrixData3[15:8];
    assign p33 = InMatrixData3[7:0];

    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    logic        de_prev_q;
    logic        border_d;

    logic [9:0]  s1_gxp_q, s1_gxp_d;
    logic [9:0]  s1_gxn_q, s1_gxn_d;
    logic [9:0]  s1_gyp_q, s1_gyp_d;
    logic [9:0]  s1_gyn_q, s1_gyn_d;
    logic [7:0]  s1_thr_q;
    logic        s1_border_q;
    logic        s1_de_q;

    logic [9:0]  s2_gx_q, s2_gx_d;
    logic [9:0]  s2_gy_q, s2_gy_d;
    logic [7:0]  s2_thr_q;
    logic        s2_border_q;
    logic        s2_de_q;

    logic [10:0] s3_mag_q, s3_mag_d;
    logic [7:0]  s3_thr_q;
    logic        s3_border_q;
    logic        s3_de_q;

    // col_q is the index of the pixel currently on the input; it is zero
    // on the first valid cycle because idle cycles force it back to zero.
    always_comb begin
        col_d = InMatrixDe ? col_q + 16'd1 : '0;
        row_d = row_q;
        if (de_prev_q && !InMatrixDe) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 16'd1;
        end
        border_d = (col_q < 16'd2) || (row_q < 16'd2);
    end

    always_comb begin
        s1_gxp_d = {2'b00, p13} + {1'b0, p23, 1'b0} + {2'b00, p33};
        s1_gxn_d = {2'b00, p11} + {1'b0, p21, 1'b0} + {2'b00, p31};
        s1_gyp_d = {2'b00, p31} + {1'b0, p32, 1'b0} + {2'b00, p33};
        s1_gyn_d = {2'b00, p11} + {1'b0, p12, 1'b0} + {2'b00, p13};
    end

    always_comb begin
        s2_gx_d = (s1_gxp_q >= s1_gxn_q) ? (s1_gxp_q - s1_gxn_q) : (s1_gxn_q - s1_gxp_q);
        s2_gy_d = (s1_gyp_q >= s1_gyn_q) ? (s1_gyp_q - s1_gyn_q) : (s1_gyn_q - s1_gyp_q);
        s3_mag_d = {1'b0, s2_gx_q} + {1'b0, s2_gy_q};
    end

    always_ff @(posedge InClk) begin
        if (!InRst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            de_prev_q   <= 1'b0;
            s1_gxp_q    <= '0;
            s1_gxn_q    <= '0;
            s1_gyp_q    <= '0;
            s1_gyn_q    <= '0;
            s1_thr_q    <= '0;
            s1_border_q <= 1'b0;
            s1_de_q     <= 1'b0;
            s2_gx_q     <= '0;
            s2_gy_q     <= '0;
            s2_thr_q    <= '0;
            s2_border_q <= 1'b0;
            s2_de_q     <= 1'b0;
            s3_mag_q    <= '0;
            s3_thr_q    <= '0;
            s3_border_q <= 1'b0;
            s3_de_q     <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            de_prev_q   <= InMatrixDe;
            s1_gxp_q    <= s1_gxp_d;
            s1_gxn_q    <= s1_gxn_d;
            s1_gyp_q    <= s1_gyp_d;
            s1_gyn_q    <= s1_gyn_d;
            s1_thr_q    <= InThreshold;
            s1_border_q <= border_d;
            s1_de_q     <= InMatrixDe;
            s2_gx_q     <= s2_gx_d;
            s2_gy_q     <= s2_gy_d;
            s2_thr_q    <= s1_thr_q;
            s2_border_q <= s1_border_q;
            s2_de_q     <= s1_de_q;
            s3_mag_q    <= s3_mag_d;
            s3_thr_q    <= s2_thr_q;
            s3_border_q <= s2_border_q;
            s3_de_q     <= s2_de_q;
        end
    end

    always_comb begin
        OutDe   = s3_de_q;
        OutData = '0;
        OutEdge = 1'b0;
        if (s3_de_q && !s3_border_q) begin
            OutData = (s3_mag_q > 11'd255) ? 8'hFF : s3_mag_q[7:0];
            OutEdge = (s3_mag_q > {3'b000, s3_thr_q});
        end
    end

endmodule
